// File: rtl/gray_encoder_pkg.sv
// -----------------------------------------------------------------------------
// gray_encoder_pkg
//   Shared definitions for the streaming binary-to-Gray encoder.
//   - MAX_W     : widest word the helper functions handle; callers zero-extend.
//   - word_t    : MAX_W-bit container used by the helpers.
//   - entry_t   : width-independent view of one pipeline entry {valid, gray, step}.
//   - bin2gray  : binary to reflected Gray code.
//   - is_single_step : true when two Gray words differ in exactly one bit.
// -----------------------------------------------------------------------------
package gray_encoder_pkg;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  // One pipeline entry. The gray field is sized for the widest supported
  // word; narrower users zero-extend into it.
  typedef struct packed {
    logic  valid;
    word_t gray;
    logic  step;
  } entry_t;

  // Zero-extended inputs encode correctly for any width up to MAX_W because
  // the bit shifted in from above is always 0.
  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Exactly one differing bit: the difference is non-zero and a power of two.
  function automatic logic is_single_step(input word_t a, input word_t b);
    word_t diff;
    diff = a ^ b;
    return (diff != '0) && ((diff & (diff - word_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_skid_buf.sv
// -----------------------------------------------------------------------------
// gray_skid_buf
//   Generic 2-entry valid/ready skid buffer. Main register M drives the
//   output; skid register S catches the one word that can arrive while M is
//   stalled.
//
//   Handshake: a word moves on a side whenever valid && ready are both high at
//   the rising clock edge. in_ready is a pure flop output (!S.valid), so there
//   is no combinational path from out_ready to in_ready. Data order is kept:
//   S always refills M before any new input does.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake
//     in_data  [DW]       upstream payload
//     out_valid/out_ready downstream handshake
//     out_data [DW]       downstream payload (M register)
// -----------------------------------------------------------------------------
module gray_skid_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          s_valid;
  logic [DW-1:0] s_data;

  logic accept;
  logic fire;

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  assign accept = in_valid && in_ready;
  assign fire   = m_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else if (!m_valid || fire) begin
      // M is free this cycle: drain S first to keep order, otherwise take
      // the new word directly. accept cannot coincide with s_valid because
      // in_ready is low whenever S is occupied.
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      // M is stalled: park the incoming word in S.
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

endmodule

// File: rtl/gray_encoder.sv
// -----------------------------------------------------------------------------
// gray_encoder
//   Streaming binary-to-Gray encoder. Accepted binary words are Gray-coded,
//   tagged with a single-step flag relative to the previously encoded word,
//   and passed through a 2-entry skid buffer. Emitted words whose step flag
//   is 0 are counted in a saturating counter.
//
//   Handshake: in_valid/in_ready and out_valid/out_ready transfer a word when
//   both are high at the rising clock edge; in_ready comes straight from a
//   flop.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid, in_ready  input handshake
//     in_bin   [WIDTH]    binary input word
//     out_valid,out_ready output handshake
//     out_gray [WIDTH]    Gray-coded word
//     out_step            out_gray is one bit away from the previous encoded word
//     clr_cnt             synchronous clear of nonstep_cnt (wins over increment)
//     nonstep_cnt [CNT_W] saturating count of emitted words with out_step=0
// -----------------------------------------------------------------------------
module gray_encoder
  import gray_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_step,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] nonstep_cnt
);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("gray_encoder: WIDTH must be in 2..MAX_W");
  end

  // Payload carried through the skid buffer: {step, gray}.
  localparam int unsigned PW = WIDTH + 1;

  logic [WIDTH-1:0] in_gray;
  logic             in_step;
  logic [WIDTH-1:0] prev;
  logic             have_prev;
  logic             accept;
  logic             fire;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;

  assign in_gray = WIDTH'(bin2gray(word_t'(in_bin)));

  // The very first word after reset has nothing to be compared against and
  // is treated as a legal step. A repeated value differs in zero bits and
  // therefore is not a step.
  assign in_step = !have_prev || is_single_step(word_t'(in_gray), word_t'(prev));

  assign in_payload = {in_step, in_gray};

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  assign out_step = out_payload[WIDTH];
  assign out_gray = out_payload[WIDTH-1:0];

  // Reference point for step detection follows the encode order, not the
  // emit order; both are the same since the buffer preserves order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (accept) begin
      prev      <= in_gray;
      have_prev <= 1'b1;
    end
  end

  gray_skid_buf #(
    .DW (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonstep_cnt <= '0;
    end else if (clr_cnt) begin
      nonstep_cnt <= '0;
    end else if (fire && !out_step && (nonstep_cnt != '1)) begin
      nonstep_cnt <= nonstep_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_encoder.sv
// -----------------------------------------------------------------------------
// tb_gray_encoder
//   Self-checking bench for gray_encoder (WIDTH=4, CNT_W=8). A reference
//   model holds the expected {step, gray} words in order; every emitted word
//   is compared against it, and occupancy/counter values are derived from it.
// -----------------------------------------------------------------------------
module tb_gray_encoder;
  import gray_encoder_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_gray;
  logic             out_step;
  logic             clr_cnt;
  logic [CNT_W-1:0] nonstep_cnt;

  gray_encoder #(
    .WIDTH (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gray    (out_gray),
    .out_step    (out_step),
    .clr_cnt     (clr_cnt),
    .nonstep_cnt (nonstep_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [W:0]   exp_q[$];      // {step, gray} in emit order
  logic [W-1:0] m_prev;
  bit           m_have_prev;
  int           m_cnt;

  logic [W-1:0] sweep_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_prev      = '0;
    m_have_prev = 0;
    m_cnt       = 0;
  endfunction

  function automatic void model_accept(input logic [W-1:0] b);
    entry_t       e;
    logic [W-1:0] g;
    g       = b ^ (b >> 1);
    e.valid = 1'b1;
    e.gray  = word_t'(g);
    e.step  = !m_have_prev || (popcount(g ^ m_prev) == 1);
    exp_q.push_back({e.step, e.gray[W-1:0]});
    m_prev      = g;
    m_have_prev = 1;
  endfunction

  // One clock: account for the transfers about to happen at the next rising
  // edge, let it happen, then check at the falling edge.
  task automatic tick();
    bit         acc;
    bit         fr;
    bit         nonstep_fire;
    logic [W:0] e;
    acc          = in_valid && in_ready;
    fr           = out_valid && out_ready;
    nonstep_fire = 0;
    if (fr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_gray", 32'(out_gray), 32'(e[W-1:0]));
        check("out_step", 32'(out_step), 32'(e[W]));
        nonstep_fire = !e[W];
      end
    end
    if (clr_cnt) m_cnt = 0;
    else if (nonstep_fire && m_cnt < CNT_MAX) m_cnt++;
    if (acc) model_accept(in_bin);
    @(posedge clk);
    @(negedge clk);
    check("nonstep_cnt", 32'(nonstep_cnt), 32'(m_cnt));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_gray"}, 32'(out_gray), 32'd0);
    check({tag, "_out_step"}, 32'(out_step), 32'd0);
    check({tag, "_nonstep_cnt"}, 32'(nonstep_cnt), 32'd0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    in_bin    = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] b);
    in_valid = 1'b1;
    in_bin   = b;
    tick();
  endtask

  task automatic drain();
    int budget = 10;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    in_bin    = '0;
    do_reset();

    // Count sweep: 0..15 back-to-back, one cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(W'(i));
      check("sweep_gray", 32'(out_gray), 32'(sweep_tab[i]));
      check("sweep_step", 32'(out_step), 32'd1);
    end
    drain();
    check("sweep_cnt", 32'(nonstep_cnt), 32'd0);

    // Backpressure: 3 then 4 with the sink stalled.
    do_reset();
    out_ready = 1'b0;
    send(4'd3);
    send(4'd4);
    in_valid = 1'b0;
    check("bp_m_gray", 32'(out_gray), 32'h2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("bp_hold_gray", 32'(out_gray), 32'h2);
    out_ready = 1'b1;
    tick();
    check("bp_second_gray", 32'(out_gray), 32'h6);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Non-step detection: 0, 5, 5.
    do_reset();
    out_ready = 1'b1;
    send(4'd0);
    check("ns_gray0", 32'(out_gray), 32'h0);
    check("ns_step0", 32'(out_step), 32'd1);
    send(4'd5);
    check("ns_gray1", 32'(out_gray), 32'h7);
    check("ns_step1", 32'(out_step), 32'd0);
    send(4'd5);
    check("ns_gray2", 32'(out_gray), 32'h7);
    check("ns_step2", 32'(out_step), 32'd0);
    drain();
    tick();
    check("ns_cnt", 32'(nonstep_cnt), 32'd2);

    // Wrap-around: 14, 15, 0.
    do_reset();
    out_ready = 1'b1;
    send(4'd14);
    send(4'd15);
    check("wrap_gray15", 32'(out_gray), 32'h8);
    check("wrap_step15", 32'(out_step), 32'd1);
    send(4'd0);
    check("wrap_gray0", 32'(out_gray), 32'h0);
    check("wrap_step0", 32'(out_step), 32'd1);
    drain();

    // Saturation: one step word then 300 repeats.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 301; i++) send(4'd5);
    drain();
    tick();
    check("sat_cnt", 32'(nonstep_cnt), 32'd255);
    // Clear in the same cycle as a non-step fire.
    send(4'd5);
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_cnt", 32'(nonstep_cnt), 32'd0);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0, 1:    in_bin = in_bin + 4'd1;
        2:       in_bin = in_bin;
        default: in_bin = W'($urandom_range(0, (1 << W) - 1));
      endcase
      tick();
    end
    clr_cnt = 1'b0;
    drain();

    // Reset mid-flight with both entries full.
    out_ready = 1'b0;
    send(4'd6);
    send(4'd7);
    in_valid = 1'b0;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    check("mid_full_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_clear();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(4'd9);
    check("post_reset_gray", 32'(out_gray), 32'hD);
    check("post_reset_step", 32'(out_step), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
